// File: rtl/vgc_timing.sv
// Video timing generator: 14M H/V counters, blanking/sync flags, VERT/HORIZ counter
// readback and the VGC one-second / scanline interrupt registers.
module vgc_timing #(
    parameter int H_TOTAL        = 910,
    parameter int V_TOTAL        = 262,
    parameter int H_ACTIVE       = 640,
    parameter int V_VBL          = 192,
    parameter int HS_START       = 700,
    parameter int HS_END         = 767,
    parameter int VS_START       = 224,
    parameter int VS_END         = 226,
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce_14m,
    input  logic       strobe,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       scanline_irq,
    output logic [9:0] H,
    output logic [8:0] V,
    output logic       HBlank,
    output logic       VBlank,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       irq_n
);

    localparam logic [1:0] ADDR_VGCINT    = 2'd0;
    localparam logic [1:0] ADDR_VERTCNT   = 2'd1;
    localparam logic [1:0] ADDR_HORIZCNT  = 2'd2;
    localparam logic [1:0] ADDR_CLRVGCINT = 2'd3;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_W    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START_W = 10'(HS_START);
    localparam logic [9:0] HS_END_W   = 10'(HS_END);
    localparam logic [8:0] V_VBL_W    = 9'(V_VBL);
    localparam logic [8:0] VS_START_W = 9'(VS_START);
    localparam logic [8:0] VS_END_W   = 9'(VS_END);

    localparam int         FC_W    = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SEC - 1);

    logic [3:0]      hsub;
    logic [6:0]      hslot;
    logic [FC_W-1:0] frame_cnt;
    logic            sec_en;
    logic            line_en;
    logic            sec_pend;
    logic            line_pend;

    logic            h_last;
    logic            v_last;
    logic            fc_last;
    logic            rd_req;
    logic            wr_req;
    logic            line_set;
    logic            sec_set;
    logic            line_clr;
    logic            sec_clr;
    logic [8:0]      vert;
    logic [6:0]      hc;
    logic [7:0]      rd_dat;
    logic            unused_din;

    assign unused_din = ^{din[7], din[4:3], din[0]};

    assign h_last  = (H == H_LAST);
    assign v_last  = (V == V_LAST);
    assign fc_last = (frame_cnt == FC_LAST);

    assign HBlank = (H >= H_ACT_W);
    assign VBlank = (V >= V_VBL_W);
    assign hsync  = (H >= HS_START_W) && (H <= HS_END_W);
    assign vsync  = (V >= VS_START_W) && (V <= VS_END_W);

    assign rd_req = strobe & rw;
    assign wr_req = strobe & ~rw;

    assign line_set = ce_14m & h_last & scanline_irq & line_en;
    assign sec_set  = ce_14m & h_last & v_last & fc_last & sec_en;
    assign line_clr = wr_req & (addr == ADDR_CLRVGCINT) & ~din[5];
    assign sec_clr  = wr_req & (addr == ADDR_CLRVGCINT) & ~din[6];

    // Lines 256+ are reported as $FA..$FF so the count looks like 0x100..0x1FF, 0x0FA..0x0FF.
    always_comb begin
        vert = V[8] ? (9'h0FA + {1'b0, V[7:0]}) : {1'b1, V[7:0]};
        hc   = (hslot == 7'd0) ? 7'h00 : (7'h3F + hslot);
    end

    always_comb begin
        rd_dat = 8'h00;
        case (addr)
            ADDR_VGCINT:    rd_dat = {sec_pend | line_pend, sec_pend, line_pend, 2'b00,
                                      sec_en, line_en, 1'b0};
            ADDR_VERTCNT:   rd_dat = vert[8:1];
            ADDR_HORIZCNT:  rd_dat = {vert[0], hc};
            ADDR_CLRVGCINT: rd_dat = 8'h00;
            default:        rd_dat = 8'h00;
        endcase
    end

    // Beam counters; the 0..13 sub-counter replaces an H/14 divider for the slot number.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            H           <= 10'd0;
            V           <= 9'd0;
            hsub        <= 4'd0;
            hslot       <= 7'd0;
            frame_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= ce_14m & h_last & v_last;
            if (ce_14m) begin
                if (h_last) begin
                    H     <= 10'd0;
                    hsub  <= 4'd0;
                    hslot <= 7'd0;
                    if (v_last) begin
                        V         <= 9'd0;
                        frame_cnt <= fc_last ? '0 : frame_cnt + 1'b1;
                    end else begin
                        V <= V + 9'd1;
                    end
                end else begin
                    H <= H + 10'd1;
                    if (hsub == 4'd13) begin
                        hsub  <= 4'd0;
                        hslot <= hslot + 7'd1;
                    end else begin
                        hsub <= hsub + 4'd1;
                    end
                end
            end
        end
    end

    // Pending bits: a set arriving in the same cycle as a clear takes priority.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sec_en    <= 1'b0;
            line_en   <= 1'b0;
            sec_pend  <= 1'b0;
            line_pend <= 1'b0;
            irq_n     <= 1'b1;
            dout      <= 8'h00;
        end else begin
            if (wr_req && (addr == ADDR_VGCINT)) begin
                sec_en  <= din[2];
                line_en <= din[1];
            end
            sec_pend  <= sec_set  | (sec_pend  & ~sec_clr);
            line_pend <= line_set | (line_pend & ~line_clr);
            irq_n     <= ~(sec_pend | line_pend);
            if (rd_req) begin
                dout <= rd_dat;
            end
        end
    end

endmodule

// File: tb/tb_vgc_timing.sv
// Directed bench for vgc_timing with a shortened line (two slots) so whole frames stay cheap.
module tb_vgc_timing;

    localparam int HT = 28;
    localparam int VT = 262;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ce_14m = 1'b0;
    logic       strobe = 1'b0;
    logic       rw = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       scanline_irq = 1'b0;
    logic [9:0] H;
    logic [8:0] V;
    logic       HBlank, VBlank, hsync, vsync, frame_start, irq_n;

    int checks = 0;
    int errors = 0;
    int fs_cnt;
    int vbl_lines;

    vgc_timing #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(20), .V_VBL(192),
        .HS_START(22), .HS_END(24), .VS_START(224), .VS_END(226),
        .FRAMES_PER_SEC(2)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_14m(ce_14m), .strobe(strobe),
        .rw(rw), .addr(addr), .din(din), .dout(dout), .scanline_irq(scanline_irq),
        .H(H), .V(V), .HBlank(HBlank), .VBlank(VBlank), .hsync(hsync),
        .vsync(vsync), .frame_start(frame_start), .irq_n(irq_n)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each task starts and ends at a falling edge.
    task automatic run(input int n);
        fs_cnt    = 0;
        vbl_lines = 0;
        ce_14m    = 1'b1;
        repeat (n) begin
            @(negedge clk_sys);
            if (frame_start) fs_cnt++;
            if (VBlank && H == 10'd0) vbl_lines++;
        end
        ce_14m = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic ce);
        strobe = 1'b1; rw = 1'b1; addr = a; ce_14m = ce;
        @(negedge clk_sys);
        strobe = 1'b0; ce_14m = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic ce);
        strobe = 1'b1; rw = 1'b0; addr = a; din = d; ce_14m = ce;
        @(negedge clk_sys);
        strobe = 1'b0; ce_14m = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        chk("rst_H", 16'(H), 16'd0);
        chk("rst_V", 16'(V), 16'd0);
        chk("rst_irq_n", 16'(irq_n), 16'd1);
        chk("rst_dout", 16'(dout), 16'h00);
        chk("rst_fs", 16'(frame_start), 16'd0);
        chk("rst_flags", 16'({HBlank, VBlank, hsync, vsync}), 16'd0);
        reset = 1'b0;
        @(negedge clk_sys);
        chk("hold_H", 16'(H), 16'd0);

        run(HT * VT);
        chk("frame_start_cnt", 16'(fs_cnt), 16'd1);
        chk("vblank_lines", 16'(vbl_lines), 16'd70);
        chk("wrap_H", 16'(H), 16'd0);
        chk("wrap_V", 16'(V), 16'd0);

        run(14);
        rd(2'd1, 1'b0);
        chk("vert_v0", 16'(dout), 16'h80);
        rd(2'd2, 1'b1);
        chk("horiz_h14", 16'(dout), 16'h40);
        chk("ce_with_strobe_H", 16'(H), 16'd15);

        run(5);
        chk("hblank_h20", 16'({HBlank, hsync}), 16'b10);
        run(2);
        chk("hsync_h22", 16'({HBlank, hsync}), 16'b11);
        run(3);
        chk("hsync_h25", 16'({HBlank, hsync}), 16'b10);

        run(3 + 223 * HT);
        chk("v224_pos", 16'({V, 1'b0} + 16'(H)), 16'(224 * 2));
        chk("vsync_v224", 16'({VBlank, vsync}), 16'b11);
        run(32 * HT);
        chk("v256_V", 16'(V), 16'd256);
        rd(2'd1, 1'b0);
        chk("vert_v256", 16'(dout), 16'h7D);
        rd(2'd2, 1'b0);
        chk("horiz_v256", 16'(dout), 16'h00);

        wr(2'd0, 8'h02, 1'b0);
        rd(2'd0, 1'b0);
        chk("line_en_rd", 16'(dout), 16'h02);
        scanline_irq = 1'b1;
        run(HT);
        scanline_irq = 1'b0;
        rd(2'd0, 1'b0);
        chk("line_pend_rd", 16'(dout), 16'hA2);
        chk("line_irq_n", 16'(irq_n), 16'd0);
        wr(2'd3, 8'hDF, 1'b0);
        rd(2'd0, 1'b0);
        chk("line_clr_rd", 16'(dout), 16'h02);
        chk("line_clr_irq_n", 16'(irq_n), 16'd1);

        scanline_irq = 1'b1;
        run(HT - 1);
        wr(2'd3, 8'hDF, 1'b1);
        scanline_irq = 1'b0;
        rd(2'd0, 1'b0);
        chk("set_beats_clr", 16'(dout), 16'hA2);

        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        wr(2'd0, 8'h04, 1'b0);
        rd(2'd0, 1'b0);
        chk("sec_en_rd", 16'(dout), 16'h04);
        run(2 * HT * VT);
        chk("sec_irq_n_lag", 16'({irq_n, frame_start}), 16'b11);
        @(negedge clk_sys);
        chk("sec_irq_n", 16'(irq_n), 16'd0);
        rd(2'd0, 1'b0);
        chk("sec_pend_rd", 16'(dout), 16'hC4);

        run(100 * HT);
        chk("v100_V", 16'(V), 16'd100);
        reset = 1'b1;
        #1;
        chk("async_rst_HV", 16'({V, 1'b0} + 16'(H)), 16'd0);
        chk("async_rst_irq_n", 16'(irq_n), 16'd1);
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        rd(2'd0, 1'b0);
        chk("post_rst_rd", 16'(dout), 16'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
